fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the mMips pipeline. It sits directly upstream of the hazard detection unit: it owns the PC and the IF/ID pipeline register, and drives the instruction-memory handshake. It produces the `Instr` word that the hazard unit decodes, and consumes that unit's `PCWrite`, `IFIDWrite` and `imem_en` decisions plus branch redirects from ID. It handles memory wait states, nop insertion and a one-entry holding buffer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_WORD`, default 32'h0000_0000: word loaded into IF/ID when no valid instruction is available (`sll $0,$0,0`).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `PCWrite`, in, 1: from hazard unit; allows the PC to advance.
- `IFIDWrite`, in, 1: from hazard unit; allows IF/ID to load.
- `fetch_en`, in, 1: hazard unit `imem_en`; permits a memory fetch this cycle.
- `BranchTaken`, in, 1: branch resolved taken in ID.
- `BranchTarget`, in, 32: redirect address; bits [1:0] are ignored.
- `imem_wait`, in, 1: instruction memory not ready; `imem_rdata` is invalid.
- `imem_rdata`, in, 32: instruction word, valid the same cycle that `imem_en`=1 and `imem_wait`=0.
- `imem_en`, out, 1: memory request strobe.
- `imem_addr`, out, 32: equals the PC register.
- `Instr`, out, 32: IF/ID instruction.
- `IFIDPC`, out, 32: IF/ID PC+4 of `Instr`.
- `IFIDValid`, out, 1: `Instr` is a real fetch, not an inserted nop.

## Operation
- **Reset values:** PC=`RESET_PC`, `Instr`=`NOP_WORD`, `IFIDPC`=0, `IFIDValid`=0, buffer empty, state=BOOT. `imem_en`=0 while `rst` is high.
- **States:**
  - BOOT: one cycle; no request is issued; goes to RUN.
  - RUN: `imem_en`=`fetch_en`.
  - WAIT: request outstanding; `imem_en`=1, address held.
  - HOLD: buffer full; `imem_en`=0.
- **Fetch hit** (RUN or WAIT, `imem_en`=1, `imem_wait`=0) delivers `imem_rdata` as the "fetched word".
- **RUN → WAIT:** `imem_en`=1 and `imem_wait`=1. **WAIT → RUN:** on the first cycle `imem_wait`=0.
- **PC update priority**, evaluated in order:
  1. `rst`.
  2. `BranchTaken`: PC ← {`BranchTarget`[31:2],2'b00}.
  3. Fetched word available and `PCWrite`: PC ← PC+4, wrapping modulo 2^32.
  4. Otherwise PC holds.
- **IF/ID update:**
  - `BranchTaken`: load `NOP_WORD`, `IFIDValid`=0, flush the buffer; state → RUN. This applies even if `IFIDWrite`=0 or `imem_wait`=1; an outstanding request is abandoned.
  - Else if `IFIDWrite`=1: load the buffer if it is full, else the fetched word if one is available, else `NOP_WORD` with `IFIDValid`=0.
  - Else IF/ID holds.
- `IFIDPC` loads the address of the loaded word plus 4.
- **Buffer capture** (macro enabled): fetched word available with `PCWrite`=1 and `IFIDWrite`=0 stores word+PC into the buffer; state → HOLD.
  - HOLD → RUN when `IFIDWrite`=1 drains the buffer.
  - A fetch concurrent with the drain is not issued, because `imem_en`=0 in HOLD.

## Timing
- **Latency:** address A is on `imem_addr` in cycle n with a hit; `Instr`=word(A) and `IFIDPC`=A+4 are visible in cycle n+1.
- **Throughput:** one instruction per cycle with no stalls.
- **Wait states:** each `imem_wait` cycle adds exactly one cycle. `imem_addr` is stable throughout WAIT.
- **Redirect:** `BranchTaken` in cycle n gives `imem_addr`=target in n+1 and `Instr`=nop in n+1. The target instruction appears in `Instr` at n+2.
- **Reset mid-WAIT or mid-HOLD:** next cycle the block is in BOOT with reset values; the outstanding request is dropped.

## Configuration
- `FETCH_HOLD_BUFFER_EN` **defined:** one-entry buffer and HOLD state as above.
- **Undefined:** no buffer and no HOLD state. The PC advances only when `PCWrite`=1 and `IFIDWrite`=1 (rule 3 gains the `IFIDWrite` condition). A word fetched while `IFIDWrite`=0 is discarded and re-fetched from the same address.

## Structure
- Shared package `mmips_pkg` holds:
  - the state encoding typedef `fetch_state_t` (BOOT, RUN, WAIT, HOLD);
  - the `NOP_WORD` constant;
  - the PC increment constant (4).
- One sub-module `fetch_hold_buf`: a one-entry valid/data/PC register with load, drain and flush inputs. It is instantiated only under `FETCH_HOLD_BUFFER_EN`.

## Test plan
- **Reset and streaming:** `rst`=1 for 2 cycles, then streaming with no waits. Required: `imem_en`=0 during reset and during BOOT; `imem_addr` runs 0, 4, 8; `Instr` follows one cycle later; `IFIDPC`=4, 8, 12.
- **Wait states:** `imem_wait`=1 for 3 cycles at address 0x10. Required: `imem_addr` holds 0x10 for 4 cycles; `Instr` holds the previous word; after wait drops, `Instr`=word(0x10) and `IFIDPC`=0x14.
- **Branch redirect:** `BranchTaken` with `BranchTarget`=0x100 while the PC is 0x24. Required: next cycle `imem_addr`=0x100 and `Instr`=0 with `IFIDValid`=0; following cycle `Instr`=word(0x100). Also apply the same redirect while `imem_wait`=1; the redirect must still take effect next cycle.
- **Hold buffer:** `PCWrite`=1, `IFIDWrite`=0 at PC 0x40.
  - Macro on: buffer captures word(0x40) and the PC goes to 0x44; with `IFIDWrite`=1 the next cycle, `Instr`=word(0x40) and there is no memory request in that cycle.
  - Macro off: PC stays 0x40 and is re-fetched.
- **Nop insertion:** `fetch_en`=0, `IFIDWrite`=1. Required: `Instr`=`NOP_WORD`, `IFIDValid`=0, PC unchanged.
- **Reset and wrap-around:** `rst` asserted while in HOLD, which returns to BOOT with the buffer empty. Separately, PC=0xFFFF_FFFC streaming wraps to 0x0000_0000.

Source files
------------

// File: rtl/mmips_pkg.sv
// Shared mMips pipeline definitions: fetch FSM state encoding, nop word and PC step.
package mmips_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for a fetched word and its address, used while ID stalls.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_flush,
    input  logic [31:0] i_word,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_word,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_word;
    logic [31:0] r_pc;

    // Flush beats load so a redirect never leaves a stale wrong-path word behind.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
            r_word  <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
            r_pc    <= i_pc;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// mMips instruction-fetch stage: PC, IF/ID register and imem handshake.
// Define FETCH_HOLD_BUFFER_EN to add the one-entry holding buffer and HOLD state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = mmips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        fetch_en,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        imem_wait,
    input  logic [31:0] imem_rdata,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] Instr,
    output logic [31:0] IFIDPC,
    output logic        IFIDValid
);

    import mmips_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ifidPc;
    logic        r_ifidValid;

    logic        w_hit;
    logic        w_capture;
    logic        w_advance;
    logic        w_bufValid;
    logic [31:0] w_bufWord;
    logic [31:0] w_bufPc;

    assign imem_en   = !rst && ((r_state == RUN && fetch_en) || r_state == WAIT);
    assign imem_addr = r_pc;
    assign w_hit     = imem_en && !imem_wait;

`ifdef FETCH_HOLD_BUFFER_EN
    assign w_capture = w_hit && PCWrite && !IFIDWrite && !BranchTaken;
    assign w_advance = w_hit && PCWrite;

    fetch_hold_buf u_holdBuf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_capture),
        .i_drain (IFIDWrite),
        .i_flush (BranchTaken),
        .i_word  (imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_bufValid),
        .o_word  (w_bufWord),
        .o_pc    (w_bufPc)
    );
`else
    // Without a buffer, a word ID cannot accept is dropped and fetched again later.
    assign w_capture  = 1'b0;
    assign w_advance  = w_hit && PCWrite && IFIDWrite;
    assign w_bufValid = 1'b0;
    assign w_bufWord  = NOP_WORD;
    assign w_bufPc    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= BOOT;
        else     r_state <= w_nextState;
    end

    // A taken branch abandons any outstanding request or held word.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BOOT: w_nextState = RUN;
            RUN: begin
                if (imem_en && imem_wait) w_nextState = WAIT;
                else if (w_capture)       w_nextState = HOLD;
            end
            WAIT: begin
                if (!imem_wait) w_nextState = w_capture ? HOLD : RUN;
            end
            HOLD: begin
                if (IFIDWrite) w_nextState = RUN;
            end
            default: w_nextState = BOOT;
        endcase
        if (BranchTaken) w_nextState = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_instr     <= NOP_WORD;
            r_ifidPc    <= '0;
            r_ifidValid <= 1'b0;
        end else begin
            if (BranchTaken)    r_pc <= {BranchTarget[31:2], 2'b00};
            else if (w_advance) r_pc <= r_pc + PC_INC;

            // A held word is older than anything fetched now, so it drains first.
            if (BranchTaken) begin
                r_instr     <= NOP_WORD;
                r_ifidPc    <= r_pc + PC_INC;
                r_ifidValid <= 1'b0;
            end else if (IFIDWrite) begin
                if (w_bufValid) begin
                    r_instr     <= w_bufWord;
                    r_ifidPc    <= w_bufPc + PC_INC;
                    r_ifidValid <= 1'b1;
                end else if (w_hit) begin
                    r_instr     <= imem_rdata;
                    r_ifidPc    <= r_pc + PC_INC;
                    r_ifidValid <= 1'b1;
                end else begin
                    r_instr     <= NOP_WORD;
                    r_ifidPc    <= r_pc + PC_INC;
                    r_ifidValid <= 1'b0;
                end
            end
        end
    end

    assign Instr     = r_instr;
    assign IFIDPC    = r_ifidPc;
    assign IFIDValid = r_ifidValid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; honours FETCH_HOLD_BUFFER_EN when defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        fetch_en;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        imem_wait;
    logic [31:0] imem_rdata;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] Instr;
    logic [31:0] IFIDPC;
    logic        IFIDValid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .fetch_en     (fetch_en),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .imem_wait    (imem_wait),
        .imem_rdata   (imem_rdata),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .Instr        (Instr),
        .IFIDPC       (IFIDPC),
        .IFIDValid    (IFIDValid)
    );

    // Memory contents are a fixed scramble of the address so every word is distinct from the nop.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = memWord(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; fetch_en = 1'b1;
        BranchTaken = 1'b0; BranchTarget = '0; imem_wait = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_en0 got=%b exp=0", imem_en); end
        tick();
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_en1 got=%b exp=0", imem_en); end
        tick();
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got=%h exp=0", Instr); end
        checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b exp=0", IFIDValid); end
        checks++; if (IFIDPC !== 32'h0) begin errors++; $display("[TB] FAIL rst_ifidpc got=%h exp=0", IFIDPC); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr got=%h exp=0", imem_addr); end
        rst = 1'b0;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL boot_en got=%b exp=0", imem_en); end
        tick();
    endtask

    task automatic test_stream();
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL run_en got=%b exp=1", imem_en); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL stream_a0 got=%h exp=0", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL stream_a4 got=%h exp=4", imem_addr); end
        checks++; if (Instr !== 32'hDEAD_0000) begin errors++; $display("[TB] FAIL stream_i0 got=%h exp=dead0000", Instr); end
        checks++; if (IFIDPC !== 32'h4) begin errors++; $display("[TB] FAIL stream_p4 got=%h exp=4", IFIDPC); end
        checks++; if (IFIDValid !== 1'b1) begin errors++; $display("[TB] FAIL stream_v got=%b exp=1", IFIDValid); end
        tick();
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL stream_a8 got=%h exp=8", imem_addr); end
        checks++; if (Instr !== 32'hDEAD_0004) begin errors++; $display("[TB] FAIL stream_i4 got=%h exp=dead0004", Instr); end
        checks++; if (IFIDPC !== 32'h8) begin errors++; $display("[TB] FAIL stream_p8 got=%h exp=8", IFIDPC); end
        tick();
        checks++; if (IFIDPC !== 32'hC) begin errors++; $display("[TB] FAIL stream_p12 got=%h exp=c", IFIDPC); end
        tick();
    endtask

    task automatic test_wait_states();
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL wait_start got=%h exp=10", imem_addr); end
        imem_wait = 1'b1; IFIDWrite = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL wait_addr%0d got=%h exp=10", c, imem_addr); end
            checks++; if (Instr !== 32'hDEAD_000C) begin errors++; $display("[TB] FAIL wait_instr%0d got=%h exp=dead000c", c, Instr); end
            checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL wait_en%0d got=%b exp=1", c, imem_en); end
        end
        tick();
        imem_wait = 1'b0; IFIDWrite = 1'b1;
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL wait_addr_last got=%h exp=10", imem_addr); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0010) begin errors++; $display("[TB] FAIL wait_word got=%h exp=dead0010", Instr); end
        checks++; if (IFIDPC !== 32'h14) begin errors++; $display("[TB] FAIL wait_pc got=%h exp=14", IFIDPC); end
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL wait_next got=%h exp=14", imem_addr); end
    endtask

    task automatic test_branch();
        for (int c = 0; c < 4; c++) tick();
        checks++; if (imem_addr !== 32'h24) begin errors++; $display("[TB] FAIL br_pre got=%h exp=24", imem_addr); end
        BranchTaken = 1'b1; BranchTarget = 32'h0000_0103;
        tick();
        BranchTaken = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL br_addr got=%h exp=100", imem_addr); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL br_nop got=%h exp=0", Instr); end
        checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL br_valid got=%b exp=0", IFIDValid); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0100) begin errors++; $display("[TB] FAIL br_target got=%h exp=dead0100", Instr); end
        checks++; if (IFIDPC !== 32'h104) begin errors++; $display("[TB] FAIL br_pc got=%h exp=104", IFIDPC); end
        imem_wait = 1'b1; IFIDWrite = 1'b0;
        tick();
        BranchTaken = 1'b1; BranchTarget = 32'h0000_0200;
        tick();
        BranchTaken = 1'b0; imem_wait = 1'b0; IFIDWrite = 1'b1;
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL brw_addr got=%h exp=200", imem_addr); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL brw_nop got=%h exp=0", Instr); end
        checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL brw_valid got=%b exp=0", IFIDValid); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0200) begin errors++; $display("[TB] FAIL brw_target got=%h exp=dead0200", Instr); end
    endtask

    task automatic test_hold_buffer();
        BranchTaken = 1'b1; BranchTarget = 32'h40;
        tick();
        BranchTaken = 1'b0; IFIDWrite = 1'b0; PCWrite = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL hold_req got=%b exp=1", imem_en); end
        tick();
`ifdef FETCH_HOLD_BUFFER_EN
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("[TB] FAIL hold_pc got=%h exp=44", imem_addr); end
        IFIDWrite = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL hold_noreq got=%b exp=0", imem_en); end
`else
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL hold_pc got=%h exp=40", imem_addr); end
        IFIDWrite = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b1) begin errors++; $display("[TB] FAIL hold_refetch got=%b exp=1", imem_en); end
`endif
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL hold_instr_held got=%h exp=0", Instr); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0040) begin errors++; $display("[TB] FAIL hold_word got=%h exp=dead0040", Instr); end
        checks++; if (IFIDPC !== 32'h44) begin errors++; $display("[TB] FAIL hold_ifidpc got=%h exp=44", IFIDPC); end
        checks++; if (imem_addr !== 32'h44) begin errors++; $display("[TB] FAIL hold_addr got=%h exp=44", imem_addr); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0044) begin errors++; $display("[TB] FAIL hold_next got=%h exp=dead0044", Instr); end
        checks++; if (imem_addr !== 32'h48) begin errors++; $display("[TB] FAIL hold_next_addr got=%h exp=48", imem_addr); end
    endtask

    task automatic test_nop_insert();
        fetch_en = 1'b0; IFIDWrite = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL nop_en got=%b exp=0", imem_en); end
        tick();
        checks++; if (Instr !== 32'h0) begin errors++; $display("[TB] FAIL nop_instr got=%h exp=0", Instr); end
        checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL nop_valid got=%b exp=0", IFIDValid); end
        tick();
        checks++; if (imem_addr !== 32'h48) begin errors++; $display("[TB] FAIL nop_pc got=%h exp=48", imem_addr); end
        fetch_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        IFIDWrite = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_en got=%b exp=0", imem_en); end
        tick();
        rst = 1'b0; IFIDWrite = 1'b1;
        #1;
        checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL rmid_boot got=%b exp=0", imem_en); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_addr got=%h exp=0", imem_addr); end
        checks++; if (IFIDValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got=%b exp=0", IFIDValid); end
        tick();
        tick();
        checks++; if (Instr !== 32'hDEAD_0000) begin errors++; $display("[TB] FAIL rmid_buf_empty got=%h exp=dead0000", Instr); end
        checks++; if (IFIDPC !== 32'h4) begin errors++; $display("[TB] FAIL rmid_ifidpc got=%h exp=4", IFIDPC); end
    endtask

    task automatic test_wrap();
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        BranchTaken = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pre got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr got=%h exp=0", imem_addr); end
        checks++; if (Instr !== 32'h2152_FFFC) begin errors++; $display("[TB] FAIL wrap_instr got=%h exp=2152fffc", Instr); end
        checks++; if (IFIDPC !== 32'h0) begin errors++; $display("[TB] FAIL wrap_ifidpc got=%h exp=0", IFIDPC); end
        tick();
        checks++; if (Instr !== 32'hDEAD_0000) begin errors++; $display("[TB] FAIL wrap_next got=%h exp=dead0000", Instr); end
        checks++; if (IFIDPC !== 32'h4) begin errors++; $display("[TB] FAIL wrap_next_pc got=%h exp=4", IFIDPC); end
    endtask

    initial begin
        #20000;
        errors++;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_branch();
        test_hold_buffer();
        test_nop_insert();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
